// File: rtl/uart_fb_cmd_ctrl_if.sv
// Framebuffer write port: ready/valid pixel write from the packet sequencer.
interface uart_fb_cmd_ctrl_if #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned COLOR_W = 8
);
  logic               fb_we;
  logic               fb_ready;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_wdata;

  modport master (output fb_we, output fb_addr, output fb_wdata, input fb_ready);
  modport slave  (input fb_we, input fb_addr, input fb_wdata, output fb_ready);
endinterface

// File: rtl/uart_fb_cmd_ctrl.sv
// UART pixel-packet sequencer feeding the framebuffer write port.
// UART_FB_CHECKSUM_EN: 7-byte packets with trailing XOR checksum; otherwise 6-byte packets.
module uart_fb_cmd_ctrl #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned COLOR_W   = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter int unsigned TIMEOUT   = 104170
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               drdy,
  input  logic [7:0]         rx_data,
  uart_fb_cmd_ctrl_if.master fb,
  output logic               pkt_ok,
  output logic               pkt_err
);

  localparam int unsigned ADDR_W = $clog2(H_RES * V_RES);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XH,
    S_XL,
    S_YH,
    S_YL,
    S_COLOR,
`ifdef UART_FB_CHECKSUM_EN
    S_CHK,
`endif
    S_WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         xh_q, xl_q, yh_q, yl_q;
  logic [7:0]         xh_d, xl_d, yh_d, yl_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               ok_d, err_d;
  logic               in_range;
  logic [ADDR_W-1:0]  pix_addr;
`ifdef UART_FB_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  // Full 16-bit compare so out-of-range coordinates never alias into the frame.
  assign in_range = (32'({xh_q, xl_q}) < H_RES) && (32'({yh_q, yl_q}) < V_RES);
  assign pix_addr = ADDR_W'(32'({yh_q, yl_q}) * H_RES + 32'({xh_q, xl_q}));

  assign fb.fb_we    = (state_q == S_WRITE);
  assign fb.fb_addr  = addr_q;
  assign fb.fb_wdata = color_q;

  always_comb begin
    state_d = state_q;
    xh_d    = xh_q;
    xl_d    = xl_q;
    yh_d    = yh_q;
    yl_d    = yl_q;
    color_d = color_q;
    addr_d  = addr_q;
    to_d    = '0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
`ifdef UART_FB_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (drdy && rx_data == SYNC_BYTE) begin
          state_d = S_XH;
`ifdef UART_FB_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_XH: if (drdy) begin xh_d = rx_data; state_d = S_XL; end
      S_XL: if (drdy) begin xl_d = rx_data; state_d = S_YH; end
      S_YH: if (drdy) begin yh_d = rx_data; state_d = S_YL; end
      S_YL: if (drdy) begin yl_d = rx_data; state_d = S_COLOR; end
      S_COLOR: begin
        if (drdy) begin
          color_d = rx_data[COLOR_W-1:0];
`ifdef UART_FB_CHECKSUM_EN
          state_d = S_CHK;
`else
          if (in_range) begin
            state_d = S_WRITE;
            addr_d  = pix_addr;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
`endif
        end
      end
`ifdef UART_FB_CHECKSUM_EN
      S_CHK: begin
        if (drdy) begin
          if ((chk_q ^ rx_data) == 8'h00 && in_range) begin
            state_d = S_WRITE;
            addr_d  = pix_addr;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_WRITE: begin
        if (drdy) err_d = 1'b1;
        if (fb.fb_ready) begin
          state_d = S_IDLE;
          ok_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_FB_CHECKSUM_EN
    // Payload bytes all fold into the running checksum as they are stored.
    if (drdy && state_q != S_IDLE && state_q != S_WRITE && state_q != S_CHK)
      chk_d = chk_q ^ rx_data;
`endif

    // Inter-byte timeout; an arriving byte always beats expiry.
    if (state_q != S_IDLE && state_q != S_WRITE && !drdy) begin
      if (to_q == TO_W'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      xh_q    <= '0;
      xl_q    <= '0;
      yh_q    <= '0;
      yl_q    <= '0;
      color_q <= '0;
      addr_q  <= '0;
      to_q    <= '0;
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
`ifdef UART_FB_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      xh_q    <= xh_d;
      xl_q    <= xl_d;
      yh_q    <= yh_d;
      yl_q    <= yl_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      to_q    <= to_d;
      pkt_ok  <= ok_d;
      pkt_err <= err_d;
`ifdef UART_FB_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_fb_cmd_ctrl.sv
// Directed self-checking bench for uart_fb_cmd_ctrl (either UART_FB_CHECKSUM_EN build).
module tb_uart_fb_cmd_ctrl;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned TO_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       drdy;
  logic [7:0] rx_data;
  logic       pkt_ok, pkt_err;

  uart_fb_cmd_ctrl_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) fb_bus ();

  uart_fb_cmd_ctrl #(
    .H_RES    (640),
    .V_RES    (480),
    .COLOR_W  (COLOR_W),
    .SYNC_BYTE(8'hAA),
    .TIMEOUT  (TO_CLKS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .drdy   (drdy),
    .rx_data(rx_data),
    .fb     (fb_bus.master),
    .pkt_ok (pkt_ok),
    .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, ok_cnt = 0, err_cnt = 0;
  int we0, ok0, err0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_bus.fb_we) we_cnt++;
      if (pkt_ok)       ok_cnt++;
      if (pkt_err)      err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    we0 = we_cnt; ok0 = ok_cnt; err0 = err_cnt;
  endtask

  task automatic check_counts(input string tag, input int dwe, input int dok, input int derr);
    idle(4);
    check({tag, "_we"},  32'(we_cnt - we0),   32'(dwe));
    check({tag, "_ok"},  32'(ok_cnt - ok0),   32'(dok));
    check({tag, "_err"}, 32'(err_cnt - err0), 32'(derr));
  endtask

  // Returns at the falling edge just after the byte was captured.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    drdy = 1'b1;
    rx_data = b;
    @(negedge clk);
    drdy = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] c, input logic [7:0] chk_flip);
    logic [7:0] chk;
    chk = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ c ^ chk_flip;
    send_byte(8'hAA);
    send_byte(x[15:8]);
    send_byte(x[7:0]);
    send_byte(y[15:8]);
    send_byte(y[7:0]);
    send_byte(c);
`ifdef UART_FB_CHECKSUM_EN
    send_byte(chk);
`endif
  endtask

  task automatic check_write(input string tag, input logic [31:0] addr, input logic [7:0] c);
    check({tag, "_we"},    32'(fb_bus.fb_we), 32'd1);
    check({tag, "_addr"},  32'(fb_bus.fb_addr), addr);
    check({tag, "_wdata"}, 32'(fb_bus.fb_wdata), 32'(c));
    check({tag, "_ok0"},   32'(pkt_ok), 32'd0);
    @(negedge clk);
    check({tag, "_we0"},   32'(fb_bus.fb_we), 32'd0);
    check({tag, "_ok1"},   32'(pkt_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    drdy = 1'b0;
    rx_data = 8'h00;
    fb_bus.fb_ready = 1'b1;
    idle(3);
    check("rst_we",    32'(fb_bus.fb_we), 32'd0);
    check("rst_addr",  32'(fb_bus.fb_addr), 32'd0);
    check("rst_wdata", 32'(fb_bus.fb_wdata), 32'd0);
    check("rst_ok",    32'(pkt_ok), 32'd0);
    check("rst_err",   32'(pkt_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Scenario 1: x=10 y=20 colour 3C, checksum 22
    snap();
    send_pkt(16'd10, 16'd20, 8'h3C, 8'h00);
    check_write("s1", 32'd12810, 8'h3C);
    check_counts("s1", 1, 1, 0);

    // Non-sync bytes in idle are dropped silently
    snap();
    send_byte(8'h55);
    send_byte(8'h00);
    check_counts("junk", 0, 0, 0);

`ifdef UART_FB_CHECKSUM_EN
    // Scenario 2: bad checksum (0x23)
    snap();
    send_pkt(16'd10, 16'd20, 8'h3C, 8'h01);
    check_counts("s2_bad", 0, 0, 1);
    snap();
    send_pkt(16'd5, 16'd1, 8'h07, 8'h00);
    check_write("s2_good", 32'd645, 8'h07);
    check_counts("s2_good", 1, 1, 0);
`endif

    // Scenario 3: range boundaries
    snap();
    send_pkt(16'd640, 16'd0, 8'h01, 8'h00);
    check_counts("s3_x640", 0, 0, 1);
    snap();
    send_pkt(16'hFFFF, 16'd0, 8'h01, 8'h00);
    check_counts("s3_xffff", 0, 0, 1);
    snap();
    send_pkt(16'd0, 16'd480, 8'h01, 8'h00);
    check_counts("s3_y480", 0, 0, 1);
    snap();
    send_pkt(16'd639, 16'd479, 8'hFF, 8'h00);
    check_write("s3_max", 32'd307199, 8'hFF);
    check_counts("s3_max", 1, 1, 0);

    // Scenario 4: truncated packet times out TO_CLKS cycles after last byte
    snap();
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h01);
    seen = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (pkt_err) begin
        seen = j;
        break;
      end
    end
    check("s4_latency", 32'(seen), 32'(TO_CLKS));
    check_counts("s4_to", 0, 0, 1);
    snap();
    send_pkt(16'd1, 16'd0, 8'h55, 8'h00);
    check_write("s4_after", 32'd1, 8'h55);
    check_counts("s4_after", 1, 1, 0);

    // Scenario 5: stalled write with a stray byte
    snap();
    fb_bus.fb_ready = 1'b0;
    send_pkt(16'd100, 16'd2, 8'h09, 8'h00);
    for (int i = 0; i < 20; i++) begin
      check("s5_hold_we",    32'(fb_bus.fb_we), 32'd1);
      check("s5_hold_addr",  32'(fb_bus.fb_addr), 32'd1380);
      check("s5_hold_wdata", 32'(fb_bus.fb_wdata), 32'h09);
      if (i == 5) begin drdy = 1'b1; rx_data = 8'h77; end
      if (i == 6) drdy = 1'b0;
      @(negedge clk);
    end
    fb_bus.fb_ready = 1'b1;
    check_write("s5_done", 32'd1380, 8'h09);
    check_counts("s5", 21, 1, 1);

    // Scenario 6a: reset after YH byte
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h0A);
    send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    check("s6a_we",  32'(fb_bus.fb_we), 32'd0);
    check("s6a_ok",  32'(pkt_ok), 32'd0);
    check("s6a_err", 32'(pkt_err), 32'd0);
    idle(2);
    rst_n = 1'b1;
    snap();
    send_pkt(16'd3, 16'd4, 8'h21, 8'h00);
    check_write("s6a_next", 32'd2563, 8'h21);
    check_counts("s6a_next", 1, 1, 0);

    // Scenario 6b: reset while write is pending
    fb_bus.fb_ready = 1'b0;
    send_pkt(16'd7, 16'd0, 8'h42, 8'h00);
    check("s6b_pending", 32'(fb_bus.fb_we), 32'd1);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("s6b_we",   32'(fb_bus.fb_we), 32'd0);
    check("s6b_addr", 32'(fb_bus.fb_addr), 32'd0);
    @(negedge clk);
    snap();
    rst_n = 1'b1;
    fb_bus.fb_ready = 1'b1;
    check_counts("s6b_quiet", 0, 0, 0);
    snap();
    send_pkt(16'd10, 16'd20, 8'h3C, 8'h00);
    check_write("s6b_next", 32'd12810, 8'h3C);
    check_counts("s6b_next", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
